// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the two-requester memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional round-robin arbitration is enabled by MEM_ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ_IFU  = 3'd1;
    localparam logic [2:0] ST_WAIT_IFU = 3'd2;
    localparam logic [2:0] ST_REQ_LSU  = 3'd3;
    localparam logic [2:0] ST_WAIT_LSU = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        REQ_IFU  = ST_REQ_IFU,
        WAIT_IFU = ST_WAIT_IFU,
        REQ_LSU  = ST_REQ_LSU,
        WAIT_LSU = ST_WAIT_LSU
    } arb_state_t;

    // Requester identifiers, also the encoding of last_grant
    localparam logic REQ_ID_IFU = 1'b0;
    localparam logic REQ_ID_LSU = 1'b1;

    // Byte-enable width on the memory side
    localparam int MASK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational grant selection between IFU and LSU (round-robin if MEM_ARB_ROUND_ROBIN_EN, else LSU priority).
// Latency: zero, purely combinational.
// Backpressure: none; a lone requester is always granted, at most one grant is ever asserted.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_ifu,
    output logic grant_lsu
);

    logic prefer_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes next
    assign prefer_lsu = (last_grant == REQ_ID_IFU);
`else
    // Fixed priority: loads/stores always beat instruction fetch
    logic last_grant_unused;
    assign last_grant_unused = last_grant;
    assign prefer_lsu        = 1'b1;
`endif

    // LSU wins when alone or preferred; IFU takes whatever LSU did not
    always_comb begin
        grant_lsu = lsu_valid & (~ifu_valid | prefer_lsu);
        grant_ifu = ifu_valid & ~grant_lsu;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates IFU and LSU onto one memory port, one transaction at a time (MEM_ARB_ROUND_ROBIN_EN selects round-robin).
// Latency: accept -> mem request next cycle; response passed through combinationally in the cycle mem_rsp_valid arrives.
// Backpressure: requests are accepted only in IDLE; mem request fields held stable until mem_req_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [DATA_LEN-1:0] ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [DATA_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [MASK_W-1:0]   lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [MASK_W-1:0]   mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                busy
);

    arb_state_t          state_q, state_d;
    logic [DATA_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                wen_q, wen_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_ifu, grant_lsu;

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    // Handshake and memory-side outputs come straight from state and captured request
    assign ifu_req_ready = (state_q == IDLE) & grant_ifu;
    assign lsu_req_ready = (state_q == IDLE) & grant_lsu;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;
    assign busy          = (state_q != IDLE);

    // Next-state, request capture and response steering
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        last_grant_d  = last_grant_q;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Stray mem_rsp_valid is deliberately ignored here
                if (grant_ifu) begin
                    state_d      = REQ_IFU;
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    last_grant_d = REQ_ID_IFU;
                end else if (grant_lsu) begin
                    state_d      = REQ_LSU;
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                    last_grant_d = REQ_ID_LSU;
                end
            end
            REQ_IFU: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response in the same cycle as the accept finishes immediately
                    ifu_rsp_valid = mem_rsp_valid;
                    state_d       = mem_rsp_valid ? IDLE : WAIT_IFU;
                end
            end
            WAIT_IFU: begin
                if (mem_rsp_valid) begin
                    ifu_rsp_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            REQ_LSU: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    state_d       = mem_rsp_valid ? IDLE : WAIT_LSU;
                end
            end
            WAIT_LSU: begin
                if (mem_rsp_valid) begin
                    lsu_rsp_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request registers; reset abandons any open transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            last_grant_q <= REQ_ID_IFU;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter against a transaction-level model.
// Latency: n/a.
// Backpressure: exercised through mem_req_ready stalls and contention.
module tb_mem_arbiter;

    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [DL-1:0] ifu_addr, ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [DL-1:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
    logic [DL-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One open transaction at most: who owns it, whether memory has taken it, and its fields.
    bit          m_open, m_issued, m_owner, m_last, m_w;
    bit          m_wen;
    logic [DL-1:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    bit          model_grants[$];
    bit          obs_grants[$];
    int          ifu_rsp_cnt = 0;
    int          lsu_rsp_cnt = 0;

    // 0 = IFU, 1 = LSU
    function automatic bit winner(input bit iv, input bit lv, input bit last);
        if (iv && lv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b1;
`endif
        end
        return lv;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_issued = 0; m_last = 0; m_owner = 0;
            m_wen = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
        end else if (!m_open) begin
            if (ifu_req_valid || lsu_req_valid) begin
                m_w = winner(ifu_req_valid, lsu_req_valid, m_last);
                m_open = 1; m_issued = 0; m_owner = m_w; m_last = m_w;
                model_grants.push_back(m_w);
                if (m_w) begin
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end else begin
                    m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                end
            end
        end else if (!m_issued) begin
            if (mem_req_ready) begin
                if (mem_rsp_valid) m_open = 0;
                else m_issued = 1;
            end
        end else if (mem_rsp_valid) begin
            m_open = 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        bit w, e_mreq, e_irsp, e_lrsp;
        w      = winner(ifu_req_valid, lsu_req_valid, m_last);
        e_mreq = m_open && !m_issued;
        e_irsp = m_open && !m_owner && mem_rsp_valid && (m_issued || mem_req_ready);
        e_lrsp = m_open &&  m_owner && mem_rsp_valid && (m_issued || mem_req_ready);
        chk("busy", busy, m_open);
        chk("ifu_req_ready", ifu_req_ready, !m_open && ifu_req_valid && !w);
        chk("lsu_req_ready", lsu_req_ready, !m_open && lsu_req_valid && w);
        chk("mem_req_valid", mem_req_valid, e_mreq);
        chk("ifu_rsp_valid", ifu_rsp_valid, e_irsp);
        chk("lsu_rsp_valid", lsu_rsp_valid, e_lrsp);
        if (e_mreq) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", mem_wen, m_wen);
            chk("mem_wmask", mem_wmask, m_wmask);
            if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (e_irsp) chk("ifu_rdata", ifu_rdata, mem_rdata);
        if (e_lrsp && !m_wen) chk("lsu_rdata", lsu_rdata, mem_rdata);
        if (ifu_rsp_valid) ifu_rsp_cnt++;
        if (lsu_rsp_valid) lsu_rsp_cnt++;
        if (ifu_req_ready) obs_grants.push_back(1'b0);
        if (lsu_req_ready) obs_grants.push_back(1'b1);
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_i, n_l;
        bit exp_g[4];
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;

        // Reset state
        mid();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_rsp", {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 0);
        next(); next();
        rst_n = 1;

        // Single IFU read: accept c0, mem accept c1, response c3, idle c4
        next();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        mid(); chk("s1_ifu_ready", ifu_req_ready, 1);
        next();
        ifu_req_valid = 0; ifu_addr = '0; mem_req_ready = 1;
        mid(); chk("s1_mem_req_valid", mem_req_valid, 1); chk("s1_mem_addr", mem_addr, 32'h8000_0000);
        next();
        mem_req_ready = 0;
        mid(); chk("s1_busy_wait", busy, 1); chk("s1_no_early_rsp", ifu_rsp_valid, 0);
        next();
        mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        mid(); chk("s1_rsp_valid", ifu_rsp_valid, 1); chk("s1_rdata", ifu_rdata, 32'h0000_0413);
        next();
        mem_rsp_valid = 0;
        mid(); chk("s1_busy_low", busy, 0);

        // LSU write held off by 4 cycles of backpressure
        n_i = ifu_rsp_cnt; n_l = lsu_rsp_cnt;
        next();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF; lsu_wen = 1;
        mid(); chk("s2_lsu_ready", lsu_req_ready, 1);
        next();
        lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_wen = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("s2_hold_valid", mem_req_valid, 1);
            chk("s2_hold_addr", mem_addr, 32'h8000_1000);
            chk("s2_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("s2_hold_wmask", mem_wmask, 4'hF);
            chk("s2_hold_wen", mem_wen, 1);
            next();
        end
        mem_req_ready = 1;
        mid(); chk("s2_still_valid", mem_req_valid, 1);
        next();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
        mid();
        next();
        mem_rsp_valid = 0;
        mid();
        chk("s2_lsu_rsp_once", lsu_rsp_cnt - n_l, 1);
        chk("s2_no_ifu_rsp", ifu_rsp_cnt - n_i, 0);
        chk("s2_busy_low", busy, 0);

        // Contention from a fresh reset: both requesters valid for 4 transactions
        next(); rst_n = 0;
        next(); next(); rst_n = 1;
        model_grants.delete(); obs_grants.delete();
        ifu_req_valid = 1; ifu_addr = 32'h0000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h0000_0200; lsu_wen = 0;
        for (int t = 0; t < 4; t++) begin
            mem_req_ready = 0; mem_rsp_valid = 0;
            next();
            mem_req_ready = 1;
            next();
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1000 + t;
            next();
        end
        ifu_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 0;
        mid();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("s3_obs_count", obs_grants.size(), 4);
        chk("s3_model_count", model_grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_grants.size()) chk("s3_grant_dut", obs_grants[i], exp_g[i]);
            if (i < model_grants.size()) chk("s3_grant_model", model_grants[i], exp_g[i]);
        end

        // Reset while in WAIT_LSU, then stray responses in IDLE
        next();
        lsu_req_valid = 1; lsu_addr = 32'h0000_0300; lsu_wen = 0;
        next();
        lsu_req_valid = 0; mem_req_ready = 1;
        next();
        mem_req_ready = 0;
        mid(); chk("s5_busy_wait", busy, 1);
        n_i = ifu_rsp_cnt; n_l = lsu_rsp_cnt;
        #2 rst_n = 0;
        #1 chk("s5_busy_in_rst", busy, 0); chk("s5_mreq_in_rst", mem_req_valid, 0);
        next(); next();
        rst_n = 1; mem_rsp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
        mid(); chk("s5_idle", busy, 0);
        next(); next();
        mem_rsp_valid = 0;
        mid();
        chk("s5_no_lsu_rsp", lsu_rsp_cnt - n_l, 0);
        chk("s5_no_ifu_rsp", ifu_rsp_cnt - n_i, 0);

        // Same-cycle mem_req_ready and mem_rsp_valid in REQ_IFU
        next();
        ifu_req_valid = 1; ifu_addr = 32'h0000_0400;
        next();
        ifu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h0000_1234;
        mid(); chk("s6_rsp_valid", ifu_rsp_valid, 1); chk("s6_rdata", ifu_rdata, 32'h0000_1234);
        next();
        mem_req_ready = 0; mem_rsp_valid = 0;
        mid(); chk("s6_busy_low", busy, 0); chk("s6_rsp_gone", ifu_rsp_valid, 0);

        next(); next();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
